// File: rtl/int_to_float_pipe.sv
// Purpose: converts an IN_W-bit (un)signed integer to a sign / MAN_W mantissa / EXP_W exponent float (value = M * 2^E).
// Latency: 2 cycles (input register stage, then output register stage); 1 word/cycle throughput.
// Backpressure: valid/ready, bubbles collapse; in_ready is combinational from out_ready. Optional macro INT2FLOAT_ROUND_NEAREST_EN.
`timescale 1ns/1ps

module int_to_float_pipe #(
    parameter int IN_W   = 11,
    parameter int MAN_W  = 4,
    parameter int EXP_W  = 3,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [MAN_W-1:0] out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_ovf
);

    localparam int P_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    // The exponent must be able to reach the largest shift an IN_W-bit input can need.
    generate
        if (IN_W > MAN_W + (1 << EXP_W) - 1) begin : g_bad_widths
            $error("int_to_float_pipe: IN_W too large for MAN_W/EXP_W");
        end
    endgenerate

    logic             s1_valid;
    logic [IN_W-1:0]  s1_mag;
    logic             s1_sign;
    logic [P_W-1:0]   s1_p;
    logic             s1_load;
    logic             s2_load;

    logic             in_neg;
    logic [IN_W-1:0]  mag_nx;
    logic [P_W-1:0]   lead_p;

    logic [EXP_W-1:0] e_base;
    logic [MAN_W-1:0] m_trunc;
    logic [MAN_W-1:0] man_nx;
    logic [EXP_W-1:0] exp_nx;
    logic             ovf_nx;
    logic             zero_nx;

    // Output stage frees up when empty or drained; input stage when empty or moving forward.
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // Magnitude and leading-one position of the incoming word.
    always_comb begin
        in_neg = (SIGNED != 0) && in_data[IN_W-1];
        mag_nx = in_neg ? (~in_data + IN_W'(1)) : in_data;
        lead_p = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag_nx[i]) begin
                lead_p = P_W'(i);
            end
        end
    end

    // Stage 1 register: magnitude, sign, leading-one index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
            s1_sign  <= 1'b0;
            s1_p     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mag  <= mag_nx;
                s1_sign <= in_neg;
                s1_p    <= lead_p;
            end
        end
    end

`ifdef INT2FLOAT_ROUND_NEAREST_EN
    logic [IN_W-1:0]  rmask;
    logic             round_bit;
    logic             sticky;
    logic [MAN_W:0]   m_inc;
    logic [EXP_W:0]   e_inc;
`endif

    // Normalise: shift so the leading one lands in the mantissa MSB, optionally round.
    always_comb begin
        e_base = '0;
        if (int'(s1_p) > MAN_W - 1) begin
            e_base = EXP_W'(int'(s1_p) - (MAN_W - 1));
        end
        m_trunc = MAN_W'(s1_mag >> e_base);
        man_nx  = m_trunc;
        exp_nx  = e_base;
        ovf_nx  = 1'b0;
        zero_nx = (s1_mag == '0);
`ifdef INT2FLOAT_ROUND_NEAREST_EN
        rmask     = '0;
        round_bit = 1'b0;
        sticky    = 1'b0;
        m_inc     = '0;
        e_inc     = '0;
        if (e_base != '0) begin
            rmask     = IN_W'(1) << (e_base - EXP_W'(1));
            round_bit = |(s1_mag & rmask);
            sticky    = |(s1_mag & (rmask - IN_W'(1)));
        end
        if (round_bit && (sticky || m_trunc[0])) begin
            m_inc = {1'b0, m_trunc} + (MAN_W+1)'(1);
            if (m_inc[MAN_W]) begin
                // Mantissa carried out: renormalise, and saturate if the exponent overflows.
                man_nx = MAN_W'(1) << (MAN_W - 1);
                e_inc  = {1'b0, e_base} + (EXP_W+1)'(1);
                if (e_inc[EXP_W]) begin
                    man_nx = '1;
                    exp_nx = '1;
                    ovf_nx = 1'b1;
                end else begin
                    exp_nx = e_inc[EXP_W-1:0];
                end
            end else begin
                man_nx = m_inc[MAN_W-1:0];
            end
        end
`endif
    end

    // Stage 2 register: the visible outputs, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_man   <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign <= s1_sign;
                out_man  <= man_nx;
                out_exp  <= exp_nx;
                out_zero <= zero_nx;
                out_ovf  <= ovf_nx;
            end
        end
    end

endmodule

// File: tb/tb_int_to_float_pipe.sv
`timescale 1ns/1ps

module tb_int_to_float_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [10:0] in_data;
    logic        out_sign, out_zero, out_ovf;
    logic [3:0]  out_man;
    logic [2:0]  out_exp;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [10:0] s_in_data;
    logic        s_out_sign, s_out_zero, s_out_ovf;
    logic [3:0]  s_out_man;
    logic [2:0]  s_out_exp;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    int_to_float_pipe #(.IN_W(11), .MAN_W(4), .EXP_W(3), .SIGNED(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_man(out_man), .out_exp(out_exp),
        .out_zero(out_zero), .out_ovf(out_ovf)
    );

    int_to_float_pipe #(.IN_W(11), .MAN_W(4), .EXP_W(3), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sign(s_out_sign), .out_man(s_out_man), .out_exp(s_out_exp),
        .out_zero(s_out_zero), .out_ovf(s_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One isolated word through the unsigned converter with the consumer always ready.
    task automatic convert(input string tag, input logic [10:0] d,
                           input int m, input int e, input int z, input int o);
        @(negedge clk);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 check({tag, ".in_ready"}, 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, ".valid_after1"}, 32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".valid"}, 32'(out_valid), 1);
        check({tag, ".man"},   32'(out_man),   32'(m));
        check({tag, ".exp"},   32'(out_exp),   32'(e));
        check({tag, ".zero"},  32'(out_zero),  32'(z));
        check({tag, ".ovf"},   32'(out_ovf),   32'(o));
        check({tag, ".sign"},  32'(out_sign),  0);
        @(posedge clk);
    endtask

    // Hand model for small stream values 1..20.
    function automatic int exp_man(input int v);
        int m;
        m = (v < 16) ? v : (v >> 1);
`ifdef INT2FLOAT_ROUND_NEAREST_EN
        if (v >= 16 && (v & 1) == 1 && ((v >> 1) & 1) == 1) m = m + 1;
`endif
        return m;
    endfunction

    logic [10:0] s_vec_d [3];
    int          s_vec_sign [3];
    int          s_vec_man [3];
    int          s_vec_exp [3];

    initial begin
        int next, acc, rcv, cyc, held;
        bit saw_drop, pstall;
        logic [3:0] pm;
        logic [2:0] pe;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;

        // Reset: outputs stay cleared even with input offered.
        @(negedge clk);
        in_valid = 1'b1; in_data = 11'd5;
        @(negedge clk);
        @(negedge clk);
        check("rst.valid", 32'(out_valid), 0);
        check("rst.man",   32'(out_man),   0);
        check("rst.exp",   32'(out_exp),   0);
        check("rst.zero",  32'(out_zero),  0);
        check("rst.s_valid", 32'(s_out_valid), 0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        convert("d9", 11'd9, 9, 0, 0, 0);
`ifdef INT2FLOAT_ROUND_NEAREST_EN
        convert("d1000", 11'd1000, 8, 7, 0, 0);
        convert("d2047", 11'd2047, 15, 7, 0, 1);
`else
        convert("d1000", 11'd1000, 15, 6, 0, 0);
        convert("d2047", 11'd2047, 15, 7, 0, 0);
`endif
        convert("d24", 11'd24, 12, 1, 0, 0);
        convert("d0",  11'd0,  0, 0, 1, 0);
        convert("d15", 11'd15, 15, 0, 0, 0);
        convert("d16", 11'd16, 8, 1, 0, 0);

        // Signed instance: most-negative, -1, and a positive value.
        s_vec_d[0] = 11'h400; s_vec_sign[0] = 1; s_vec_man[0] = 8; s_vec_exp[0] = 7;
        s_vec_d[1] = 11'h7FF; s_vec_sign[1] = 1; s_vec_man[1] = 1; s_vec_exp[1] = 0;
        s_vec_d[2] = 11'd5;   s_vec_sign[2] = 0; s_vec_man[2] = 5; s_vec_exp[2] = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_in_data  = s_vec_d[k];
            s_in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            s_in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("sgn%0d.valid", k), 32'(s_out_valid), 1);
            check($sformatf("sgn%0d.sign", k),  32'(s_out_sign),  32'(s_vec_sign[k]));
            check($sformatf("sgn%0d.man", k),   32'(s_out_man),   32'(s_vec_man[k]));
            check($sformatf("sgn%0d.exp", k),   32'(s_out_exp),   32'(s_vec_exp[k]));
            check($sformatf("sgn%0d.zero", k),  32'(s_out_zero),  0);
        end

        // Back-to-back stream 1..20 with a 5-cycle consumer stall.
        next = 1; acc = 0; rcv = 0; cyc = 0;
        saw_drop = 1'b0; pstall = 1'b0; pm = '0; pe = '0;
        while (rcv < 20 && cyc < 200) begin
            @(negedge clk);
            in_valid  = (next <= 20);
            in_data   = next[10:0];
            out_ready = !(cyc >= 8 && cyc < 13);
            #1;
            held = acc - rcv;
            if (!in_ready && !saw_drop) begin
                saw_drop = 1'b1;
                check("stream.held_at_drop", 32'(held), 2);
            end
            if (pstall && out_valid) begin
                check("stream.stable_man", 32'(out_man), 32'(pm));
                check("stream.stable_exp", 32'(out_exp), 32'(pe));
            end
            pstall = out_valid && !out_ready;
            pm = out_man;
            pe = out_exp;
            if (in_valid && in_ready) begin
                next++;
                acc++;
            end
            if (out_valid && out_ready) begin
                rcv++;
                check($sformatf("stream%0d.man", rcv), 32'(out_man), 32'(exp_man(rcv)));
                check($sformatf("stream%0d.exp", rcv), 32'(out_exp), (rcv < 16) ? 0 : 1);
            end
            @(posedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("stream.count", 32'(rcv), 20);
        check("stream.in_ready_dropped", 32'(saw_drop), 1);
        @(negedge clk);
        #1 check("stream.drained", 32'(out_valid), 0);

        // Reset with two words in flight.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 11'd100;
        @(posedge clk);
        @(negedge clk);
        in_data = 11'd200;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("midrst.pre_valid", 32'(out_valid), 1);
        check("midrst.pre_man",   32'(out_man),   12);
        check("midrst.pre_exp",   32'(out_exp),   3);
        check("midrst.pre_in_ready", 32'(in_ready), 0);
        rst_n = 1'b0;
        #1 check("midrst.async_drop", 32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("midrst.no_stale%0d", k), 32'(out_valid), 0);
        end
        convert("post_rst_d24", 11'd24, 12, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
